decryption_unit_spi_if: RTL and testbench
=========================================

// Module: decryption_unit_spi_if
// PURPOSE
//  Serial responder front-end for the AES decryption unit, the counterpart of the
//  encryption-side responder on the same Master Mosi/Miso link.
//  - Receives 128-bit ciphertext then NK*32-bit key on Mosi while cs_dec is low.
//  - Starts the inverse-cipher core and waits for it to finish.
//  - Returns the plaintext on Miso: a 1-bit start marker, then data MSB-first.
//  - Sits between Master (cs_enc_dec, Mosi, Miso) and the inverse-cipher core.
// PARAMETERS
//  nk  4   key length in 32-bit words (4/6/8); key width KW = 32*nk
//  nb  4   block length in 32-bit words; data width DW = 32*nb (128)
//  nr  10  round count; passed through for the core, unused in this block
// PORTS
//  clk        in   1    single system clock; all logic on rising edge
//  rst        in   1    synchronous, active-high reset
//  cs_dec     in   1    chip select, active-low; frame valid while low
//  Mosi       in   1    serial data from Master, one bit per clk while cs_dec=0
//  Miso       out  1    serial data to Master
//  core_ct    out  DW   ciphertext to core (held stable from core_start until core_done)
//  core_key   out  KW   key to core (held stable from core_start until core_done)
//  core_start out  1    one-cycle start pulse to core
//  core_pt    in   DW   plaintext from core, valid when core_done=1
//  core_done  in   1    one-cycle completion pulse from core
//  busy       out  1    high in any state other than IDLE (drives status LED)
// BEHAVIOUR
//  Reset (rst=1 at a clk edge):
//   - state=IDLE, bit counter=0, Miso=0, core_start=0, busy=0; ct/key regs cleared.
//   - Takes priority over every other event in every state.
//  States:
//   - IDLE: cs_dec=0 -> sample Mosi as ct[DW-1] this cycle, go to RX_CT.
//   - RX_CT: shift Mosi into ct MSB-first; after DW bits go to RX_KEY.
//   - RX_KEY: shift KW bits into key MSB-first; on the last bit go to START.
//   - START: core_start=1 for exactly one cycle, then WAIT.
//     Last key bit sampled at edge N -> core_start high in cycle N+1.
//   - WAIT: Miso=0; core_done=1 latches core_pt into TX shift reg -> MARK.
//   - MARK: Miso=1 for one cycle (start marker) -> TX.
//   - TX: Miso = pt bits MSB-first, one per clk, DW cycles -> HOLD.
//     core_done at cycle M -> marker at M+1, pt[DW-1] at M+2, pt[0] at M+1+DW.
//   - HOLD: Miso=0; wait for cs_dec=1, then IDLE. No auto re-arm while cs stays low.
//  Abort and ignore rules:
//   - cs_dec=1 in RX_CT/RX_KEY/START/WAIT/MARK/TX -> IDLE next edge; partial data discarded.
//   - Abort before START: no core_start is issued.
//   - Abort after START: a later core_done is ignored.
//   - cs_dec rising in the same cycle as the last bit: abort wins; frame dropped.
//   - core_done outside WAIT is ignored; no latching, no state change.
//  Outputs and counters:
//   - Miso is 0 in every state except MARK/TX; it is registered (no comb path from Mosi).
//   - Bit counter width = clog2(max(DW,KW)); reset to 0 on every state entry; never wraps.
// STRUCTURE
//  - Shared header aes_params.vh: DW/KW derivation from nb/nk, state encodings
//    (IDLE..HOLD, 3 bits), MARKER bit value.
//  - Sub-module aes_spi_shift_reg #(W): W-bit shift register with load/shift_in/
//    shift_out and MSB tap.
//  - Instantiated twice: once as the SIPO ct/key receiver, once as the PISO TX register.
//  - FSM and counter live in this module.
// TESTING (bench uses a core stub: fixed 20-cycle latency, FIPS-197 table lookup)
//  - Nominal AES-128 decrypt:
//    stimulus: ct=69c4e0d86a7b0430d8cdb78070b4c55a, key=000102030405060708090a0b0c0d0e0f.
//    response: core_start one cycle after key bit 0; marker 21 cycles later;
//    Miso returns 00112233445566778899aabbccddeeff.
//  - Abort mid-key: cs_dec rises after 64 key bits.
//    response: no core_start, Miso stays 0, busy=0 next cycle.
//    A following full frame decrypts correctly.
//  - Reset mid-TX: rst=1 after 40 plaintext bits.
//    response: next edge Miso=0, busy=0, state IDLE; stray core_done afterwards ignored.
//  - Spurious core_done pulsed during RX_CT: no state change; frame completes normally.
//  - cs_dec held low after TX: stays in HOLD with Miso=0 for 50 cycles.
//    Re-arms only after cs_dec=1 then 0.
//  - nk=8: 256-bit key frame, FIPS-197 C.3 vector
//    (key 00..1f, ct 8ea2b7ca516745bfeafc49904b496089) -> 00112233..eeff.

Source files
------------

// File: rtl/decryption_unit_spi_if_pkg.sv
// Shared definitions for the decryption-side serial responder.
//   - state_t   : FSM state encoding (IDLE..HOLD, 3 bits)
//   - MARKER    : value driven on Miso for the one-cycle start marker
//   - data_width/key_width : DW/KW derivation from nb/nk (32-bit words)
package decryption_unit_spi_if_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RX_CT  = 3'd1,
        S_RX_KEY = 3'd2,
        S_START  = 3'd3,
        S_WAIT   = 3'd4,
        S_MARK   = 3'd5,
        S_TX     = 3'd6,
        S_HOLD   = 3'd7
    } state_t;

    localparam logic MARKER = 1'b1;

    function automatic int data_width(input int nb);
        return 32 * nb;
    endfunction

    function automatic int key_width(input int nk);
        return 32 * nk;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/aes_spi_shift_reg.sv
// W-bit shift register used both as the serial-in receiver and as the
// parallel-load serial-out transmit register.
//   clk, rst   : clock, synchronous active-high reset (clears contents)
//   load       : parallel load of load_data (wins over shift)
//   shift      : shift left by one, shift_in enters at bit 0
//   q          : full register contents
//   msb        : q[W-1], the serial-out tap
module aes_spi_shift_reg #(
    parameter int W = 128
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         shift,
    input  logic         shift_in,
    output logic [W-1:0] q,
    output logic         msb
);

    always_ff @(posedge clk) begin
        if (rst)
            q <= '0;
        else if (load)
            q <= load_data;
        else if (shift)
            q <= {q[W-2:0], shift_in};
    end

    assign msb = q[W-1];

endmodule

// File: rtl/decryption_unit_spi_if.sv
// Serial responder front-end for the AES inverse-cipher core.
// Receives DW-bit ciphertext then KW-bit key MSB-first on Mosi while cs_dec
// is low, pulses core_start, waits for core_done, then returns a start
// marker followed by the DW-bit plaintext MSB-first on Miso.
//   clk, rst            : clock, synchronous active-high reset
//   cs_dec              : active-low frame select
//   Mosi / Miso         : serial in / registered serial out
//   core_ct, core_key   : operands to the core, stable from start to done
//   core_start          : one-cycle start pulse
//   core_pt, core_done  : plaintext and one-cycle completion pulse
//   busy                : high whenever the FSM is not idle
module decryption_unit_spi_if
    import decryption_unit_spi_if_pkg::*;
#(
    parameter int nk = 4,
    parameter int nb = 4,
    parameter int nr = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cs_dec,
    input  logic                    Mosi,
    output logic                    Miso,
    output logic [32*nb-1:0]        core_ct,
    output logic [32*nk-1:0]        core_key,
    output logic                    core_start,
    input  logic [32*nb-1:0]        core_pt,
    input  logic                    core_done,
    output logic                    busy
);

    localparam int DW = data_width(nb);
    localparam int KW = key_width(nk);
    localparam int CW = $clog2(max2(DW, KW));

    // IDLE already captures the first ciphertext bit, so RX_CT needs DW-1 more.
    localparam logic [CW-1:0] CT_LAST  = CW'(DW - 2);
    localparam logic [CW-1:0] KEY_LAST = CW'(KW - 1);
    localparam logic [CW-1:0] TX_LAST  = CW'(DW - 1);

    // nr only matters to the core; reject unsupported shapes at elaboration.
    if (!(nk == 4 || nk == 6 || nk == 8) || nb < 1 || nr < 1) begin : g_bad_param
        $error("decryption_unit_spi_if: unsupported nk/nb/nr");
    end

    state_t          state;
    logic [CW-1:0]   bit_cnt;
    logic            miso_q;
    logic            start_q;

    logic [DW+KW-1:0] rx_q;
    logic             rx_msb;
    logic [DW-1:0]    tx_q;
    logic             tx_msb;
    logic             rx_shift, tx_load, tx_shift;
    logic             unused_taps;

    // Shift enables are gated by cs_dec so an aborting edge never moves data.
    assign rx_shift = !cs_dec && (state == S_IDLE || state == S_RX_CT || state == S_RX_KEY);
    assign tx_load  = !cs_dec && (state == S_WAIT) && core_done;
    assign tx_shift = !cs_dec && (state == S_MARK || state == S_TX);

    // Ciphertext then key arrive as one continuous MSB-first stream.
    aes_spi_shift_reg #(.W(DW + KW)) u_rx (
        .clk       (clk),
        .rst       (rst),
        .load      (1'b0),
        .load_data ('0),
        .shift     (rx_shift),
        .shift_in  (Mosi),
        .q         (rx_q),
        .msb       (rx_msb)
    );

    aes_spi_shift_reg #(.W(DW)) u_tx (
        .clk       (clk),
        .rst       (rst),
        .load      (tx_load),
        .load_data (core_pt),
        .shift     (tx_shift),
        .shift_in  (1'b0),
        .q         (tx_q),
        .msb       (tx_msb)
    );

    assign unused_taps = ^{rx_msb, tx_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            bit_cnt <= '0;
            miso_q  <= 1'b0;
            start_q <= 1'b0;
        end else begin
            start_q <= 1'b0;
            miso_q  <= 1'b0;
            if (cs_dec && state != S_IDLE && state != S_HOLD) begin
                // Deselect mid-frame drops everything, even on the last bit.
                state   <= S_IDLE;
                bit_cnt <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        bit_cnt <= '0;
                        if (!cs_dec) state <= S_RX_CT;
                    end
                    S_RX_CT: begin
                        if (bit_cnt == CT_LAST) begin
                            state   <= S_RX_KEY;
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + CW'(1);
                        end
                    end
                    S_RX_KEY: begin
                        if (bit_cnt == KEY_LAST) begin
                            state   <= S_START;
                            bit_cnt <= '0;
                            start_q <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + CW'(1);
                        end
                    end
                    S_START: begin
                        state   <= S_WAIT;
                        bit_cnt <= '0;
                    end
                    S_WAIT: begin
                        if (core_done) begin
                            state  <= S_MARK;
                            miso_q <= MARKER;
                        end
                    end
                    S_MARK: begin
                        state   <= S_TX;
                        bit_cnt <= '0;
                        miso_q  <= tx_msb;
                    end
                    S_TX: begin
                        // Last TX cycle already shows pt[0]; drop Miso on exit.
                        if (bit_cnt == TX_LAST) begin
                            state   <= S_HOLD;
                            bit_cnt <= '0;
                        end else begin
                            miso_q  <= tx_msb;
                            bit_cnt <= bit_cnt + CW'(1);
                        end
                    end
                    S_HOLD: begin
                        bit_cnt <= '0;
                        if (cs_dec) state <= S_IDLE;
                    end
                    default: begin
                        state   <= S_IDLE;
                        bit_cnt <= '0;
                    end
                endcase
            end
        end
    end

    assign Miso       = miso_q;
    assign core_start = start_q;
    assign busy       = (state != S_IDLE);
    assign core_ct    = rx_q[DW+KW-1:KW];
    assign core_key   = rx_q[KW-1:0];

endmodule

// File: tb/tb_decryption_unit_spi_if.sv
module tb_decryption_unit_spi_if;

    localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K128  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [255:0] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] BADPT = 128'hbadc0debadc0debadc0debadc0debadc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, Mosi, cs4, cs8, spur_done, sel8;

    logic         miso4, start4, busy4, done4;
    logic [127:0] ct4, key4, pt4;
    logic         miso8, start8, busy8, done8;
    logic [127:0] ct8, pt8;
    logic [255:0] key8;

    decryption_unit_spi_if #(.nk(4), .nb(4), .nr(10)) dut4 (
        .clk(clk), .rst(rst), .cs_dec(cs4), .Mosi(Mosi), .Miso(miso4),
        .core_ct(ct4), .core_key(key4), .core_start(start4),
        .core_pt(pt4), .core_done(done4), .busy(busy4)
    );

    decryption_unit_spi_if #(.nk(8), .nb(4), .nr(14)) dut8 (
        .clk(clk), .rst(rst), .cs_dec(cs8), .Mosi(Mosi), .Miso(miso8),
        .core_ct(ct8), .core_key(key8), .core_start(start8),
        .core_pt(pt8), .core_done(done8), .busy(busy8)
    );

    // Core stubs: 20-cycle latency, FIPS-197 vector lookup.
    logic       pend4 = 1'b0, pend8 = 1'b0;
    logic [4:0] lat4 = 5'd0, lat8 = 5'd0;
    int         starts4 = 0, starts8 = 0;

    always @(posedge clk) begin
        if (start4) begin
            starts4 <= starts4 + 1;
            pend4   <= 1'b1;
            lat4    <= 5'd19;
            pt4     <= (ct4 == CT128 && key4 == K128) ? PT : BADPT;
        end else if (pend4) begin
            if (lat4 == 5'd0) pend4 <= 1'b0;
            else lat4 <= lat4 - 5'd1;
        end
        if (start8) begin
            starts8 <= starts8 + 1;
            pend8   <= 1'b1;
            lat8    <= 5'd19;
            pt8     <= (ct8 == CT256 && key8 == K256) ? PT : BADPT;
        end else if (pend8) begin
            if (lat8 == 5'd0) pend8 <= 1'b0;
            else lat8 <= lat8 - 5'd1;
        end
    end

    assign done4 = (pend4 && lat4 == 5'd0) || spur_done;
    assign done8 = (pend8 && lat8 == 5'd0) || spur_done;

    logic         miso, busy, core_start;
    logic [127:0] core_ct;
    logic [255:0] core_key;
    assign miso       = sel8 ? miso8 : miso4;
    assign busy       = sel8 ? busy8 : busy4;
    assign core_start = sel8 ? start8 : start4;
    assign core_ct    = sel8 ? ct8 : ct4;
    assign core_key   = sel8 ? key8 : {128'b0, key4};

    int errs = 0, checks = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cs(input logic v);
        if (sel8) cs8 = v;
        else cs4 = v;
    endtask

    function automatic int starts();
        return sel8 ? starts8 : starts4;
    endfunction

    // Drive the first n bits of the ct-then-key stream; optional spurious done at bit spur.
    task automatic send_bits(input logic [127:0] ct, input logic [255:0] key,
                             input int kw, input int n, input int spur);
        set_cs(1'b0);
        for (int i = 0; i < n; i++) begin
            spur_done = (i == spur);
            if (i < 128) Mosi = ct[127-i];
            else Mosi = key[kw-1-(i-128)];
            tick();
        end
        spur_done = 1'b0;
    endtask

    task automatic wait_marker(input string tag);
        int k = 0;
        while (miso !== 1'b1 && k < 60) begin
            tick();
            k++;
        end
        check({tag, " marker latency"}, k, 21);
    endtask

    task automatic full_frame(input logic [127:0] ct, input logic [255:0] key,
                              input int kw, input int spur, input string tag);
        int s0;
        logic [127:0] got;
        s0 = starts();
        send_bits(ct, key, kw, 128 + kw, spur);
        check({tag, " core_start"}, core_start, 1'b1);
        check({tag, " core_ct"}, core_ct, ct);
        check({tag, " core_key"}, core_key, key);
        wait_marker(tag);
        for (int i = 0; i < 128; i++) begin
            tick();
            got[127-i] = miso;
        end
        check({tag, " plaintext"}, got, PT);
        tick();
        check({tag, " hold miso"}, miso, 1'b0);
        check({tag, " hold busy"}, busy, 1'b1);
        check({tag, " start count"}, starts() - s0, 1);
    endtask

    task automatic end_frame(input string tag);
        set_cs(1'b1);
        tick();
        check({tag, " idle busy"}, busy, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int s0, bad;
        rst = 1'b1; cs4 = 1'b1; cs8 = 1'b1; Mosi = 1'b0; spur_done = 1'b0; sel8 = 1'b0;
        tick();
        tick();
        check("reset busy4", busy4, 1'b0);
        check("reset busy8", busy8, 1'b0);
        check("reset miso4", miso4, 1'b0);
        check("reset start4", start4, 1'b0);
        check("reset ct4", ct4, '0);
        rst = 1'b0;
        tick();

        // Nominal AES-128 decrypt, then cs held low in HOLD.
        full_frame(CT128, {128'b0, K128}, 128, -1, "nom");
        s0 = starts();
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            Mosi = i[0];
            tick();
            if (miso !== 1'b0 || busy !== 1'b1) bad++;
        end
        check("hold 50 cycles", bad, 0);
        check("hold no rearm", starts() - s0, 0);
        end_frame("hold");
        set_cs(1'b0);
        tick();
        check("rearm busy", busy, 1'b1);
        end_frame("rearm");

        // Abort after 64 key bits.
        s0 = starts();
        send_bits(CT128, {128'b0, K128}, 128, 128 + 64, -1);
        set_cs(1'b1);
        tick();
        check("abort busy", busy, 1'b0);
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (miso !== 1'b0) bad++;
        end
        check("abort miso", bad, 0);
        check("abort no start", starts() - s0, 0);
        full_frame(CT128, {128'b0, K128}, 128, -1, "post-abort");
        end_frame("post-abort");

        // Spurious core_done during ciphertext reception.
        full_frame(CT128, {128'b0, K128}, 128, 50, "spurious");
        end_frame("spurious");

        // Reset after 40 plaintext bits.
        send_bits(CT128, {128'b0, K128}, 128, 256, -1);
        wait_marker("rst-tx");
        for (int i = 0; i < 40; i++) tick();
        rst = 1'b1;
        set_cs(1'b1);
        tick();
        check("rst-tx miso", miso, 1'b0);
        check("rst-tx busy", busy, 1'b0);
        check("rst-tx ct cleared", core_ct, '0);
        rst = 1'b0;
        spur_done = 1'b1;
        tick();
        spur_done = 1'b0;
        check("stray done busy", busy, 1'b0);
        check("stray done miso", miso, 1'b0);
        tick();
        check("stray done idle", busy, 1'b0);

        // AES-256 frame on the nk=8 instance.
        sel8 = 1'b1;
        full_frame(CT256, K256, 256, -1, "aes256");
        end_frame("aes256");

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
